// File: rtl/bt_pkg.sv
// Shared butterfly-unit package.
// Holds the default modulus, coefficient and tag widths, and the operation
// encodings used by the modular add/sub pipeline.
package bt_pkg;

    localparam int unsigned BT_Q  = 8380417;  // modulus
    localparam int          BT_W  = 23;       // coefficient width
    localparam int          BT_TW = 8;        // tag width

    // Encoding 2'b11 is not named: any mode with bit 1 set is a pass-through.
    typedef enum logic [1:0] {
        MODE_ADDSUB = 2'b00,
        MODE_HALF   = 2'b01,
        MODE_BYPASS = 2'b10
    } bt_mode_e;

endpackage

// File: rtl/bt_dff_arn.sv
// Standard single-bit flop of the butterfly unit.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q to 0
//   d     - next value
//   q     - registered value
module bt_dff_arn (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples the values
            // from before this edge, independent of process ordering.
            q <= d;
        end
    end

endmodule

// File: rtl/bt_mod_corr.sv
// Combinational modular correction with optional halving.
// Takes a raw value in (-Q, 2Q) and returns it reduced into [0, Q-1]; when
// half is set the reduced value x is replaced by x/2 mod Q, i.e. x>>1 for
// even x and (x+Q)>>1 for odd x.
// Ports:
//   raw  - W+2-bit two's-complement raw sum or difference
//   half - apply modular halving after the reduction
//   res  - W-bit result in [0, Q-1]
module bt_mod_corr
    import bt_pkg::*;
#(
    parameter int unsigned Q = BT_Q,
    parameter int          W = BT_W
) (
    input  logic [W+1:0] raw,
    input  logic         half,
    output logic [W-1:0] res
);

    localparam logic [W+1:0] Q_EXT = (W+2)'(Q);

    logic [W+1:0] red;

    always_comb begin
        // NOTE: every variable gets a value on entry, so no path through the
        // block leaves it unassigned and no latch is inferred.
        red = raw;
        res = '0;
        if (raw[W+1]) begin
            red = raw + Q_EXT;          // negative difference
        end else if (raw >= Q_EXT) begin
            red = raw - Q_EXT;          // sum at or above the modulus
        end
        // red < Q, so red + Q < 2^(W+1) and the W+2-bit add cannot overflow.
        if (half) begin
            res = W'((red + (red[0] ? Q_EXT : '0)) >> 1);
        end else begin
            res = W'(red);
        end
    end

endmodule

// File: rtl/bt_addsub_pipe.sv
// Two-stage modular add/subtract pipeline for the butterfly unit.
// Stage 1 registers the raw sum/difference, mode, tag and valid; stage 2
// registers the reduced (and optionally halved) results.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   en        - pipeline advance; 0 freezes every register
//   in_valid  - operands valid this cycle
//   mode      - 00 add/sub, 01 add/sub with halving, 1x pass-through
//   a, b      - operands in [0, Q-1]
//   in_tag    - index carried alongside the data
//   out_valid - results valid
//   sum, diff - results
//   out_tag   - in_tag aligned with the results
module bt_addsub_pipe
    import bt_pkg::*;
#(
    parameter int unsigned Q  = BT_Q,
    parameter int          W  = BT_W,
    parameter int          TW = BT_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [W-1:0]  sum,
    output logic [W-1:0]  diff,
    output logic [TW-1:0] out_tag
);

    logic               is_bypass;
    logic [W:0]         raw_sum;
    logic signed [W:0]  raw_diff;

    logic [W:0]         s1_sum;
    logic signed [W:0]  s1_diff;
    logic [1:0]         s1_mode;
    logic [TW-1:0]      s1_tag;
    logic               s1_valid;

    logic               v1_d;
    logic               v2_d;
    logic               half_sel;
    logic [W-1:0]       sum_corr;
    logic [W-1:0]       diff_corr;

    // Pass-through reuses the datapath: a and b ride in the sum/diff slots.
    // Both are already in [0, Q-1], so the corrector leaves them untouched.
    always_comb begin
        is_bypass = mode[1];
        raw_sum   = {1'b0, a} + {1'b0, b};
        raw_diff  = $signed({1'b0, a}) - $signed({1'b0, b});
        if (is_bypass) begin
            raw_sum  = {1'b0, a};
            raw_diff = $signed({1'b0, b});
        end
    end

    // Valid pipeline: the enable is folded into d as a recirculating hold.
    assign v1_d = en ? in_valid : s1_valid;
    assign v2_d = en ? s1_valid : out_valid;

    bt_dff_arn u_valid_s1 (.clk(clk), .rst_n(reset), .d(v1_d), .q(s1_valid));
    bt_dff_arn u_valid_s2 (.clk(clk), .rst_n(reset), .d(v2_d), .q(out_valid));

    // Data and tag load on every enabled edge; out_valid qualifies them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data registers are reset as well, so the outputs read
            // 0 while reset is held and no stale data crosses a reset.
            s1_sum  <= '0;
            s1_diff <= '0;
            s1_mode <= '0;
            s1_tag  <= '0;
        end else if (en) begin
            s1_sum  <= raw_sum;
            s1_diff <= raw_diff;
            s1_mode <= mode;
            s1_tag  <= in_tag;
        end
    end

    assign half_sel = (s1_mode == MODE_HALF);

    bt_mod_corr #(.Q(Q), .W(W)) u_corr_sum (
        .raw  ({1'b0, s1_sum}),
        .half (half_sel),
        .res  (sum_corr)
    );

    bt_mod_corr #(.Q(Q), .W(W)) u_corr_diff (
        .raw  ({s1_diff[W], s1_diff}),
        .half (half_sel),
        .res  (diff_corr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum     <= '0;
            diff    <= '0;
            out_tag <= '0;
        end else if (en) begin
            sum     <= sum_corr;
            diff    <= diff_corr;
            out_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_bt_addsub_pipe.sv
// Self-checking bench for bt_addsub_pipe. A behavioural model computes each
// result with plain modular arithmetic and schedules it to appear two
// enabled edges after it is sampled; outputs are compared on falling edges.
module tb_bt_addsub_pipe;

    localparam longint QM = 8380417;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [1:0]  mode;
    logic [22:0] a;
    logic [22:0] b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic [22:0] sum;
    logic [22:0] diff;
    logic [7:0]  out_tag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint s;
        longint d;
        int     tag;
        longint due;
    } exp_t;

    exp_t   pend[$];
    longint en_count = 0;
    logic   exp_valid = 1'b0;
    longint exp_sum = 0;
    longint exp_diff = 0;
    int     exp_tag = 0;

    bt_addsub_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .sum       (sum),
        .diff      (diff),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint half_mod(input longint x);
        return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
    endfunction

    function automatic void ref_op(input int m, input longint x, input longint y,
                                   output longint s, output longint d);
        if (m >= 2) begin
            s = x;
            d = y;
        end else begin
            s = (x + y) % QM;
            d = (x - y + QM) % QM;
            if (m == 1) begin
                s = half_mod(s);
                d = half_mod(d);
            end
        end
    endfunction

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic step();
        exp_t   e;
        longint s;
        longint d;
        @(posedge clk);
        if (!reset) begin
            pend.delete();
            exp_valid = 1'b0;
        end else if (en) begin
            if (in_valid) begin
                ref_op(int'(mode), longint'(a), longint'(b), s, d);
                pend.push_back('{s: s, d: d, tag: int'(in_tag), due: en_count + 2});
            end
            en_count++;
            if (pend.size() > 0 && pend[0].due == en_count) begin
                e = pend.pop_front();
                exp_valid = 1'b1;
                exp_sum   = e.s;
                exp_diff  = e.d;
                exp_tag   = e.tag;
            end else begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("sum", 64'(sum), 64'(exp_sum));
            check("diff", 64'(diff), 64'(exp_diff));
            check("out_tag", 64'(out_tag), 64'(exp_tag));
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [22:0] x,
                         input logic [22:0] y, input logic [7:0] t);
        in_valid = v;
        mode     = m;
        a        = x;
        b        = y;
        in_tag   = t;
    endtask

    // Single operation followed by an idle cycle, then a check against
    // hand-computed constants.
    task automatic run_one(input logic [1:0] m, input logic [22:0] x, input logic [22:0] y,
                           input logic [7:0] t, input longint es, input longint ed,
                           input string name);
        drive(1'b1, m, x, y, t);
        step();
        drive(1'b0, 2'b00, 23'd0, 23'd0, 8'd0);
        step();
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_diff"}, 64'(diff), 64'(ed));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    initial begin
        int     issued;
        logic [22:0] held_sum;
        logic        held_valid;

        reset = 1'b0;
        en    = 1'b0;
        drive(1'b0, 2'b00, 23'd0, 23'd0, 8'd0);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);

        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;

        // Directed values
        run_one(2'b00, 23'd5, 23'd3, 8'h11, 8, 2, "add_basic");
        run_one(2'b00, 23'd8380416, 23'd2, 8'h22, 1, 8380414, "add_wrap");
        run_one(2'b00, 23'd3, 23'd5, 8'h33, 8, 8380415, "sub_neg");
        run_one(2'b01, 23'd3, 23'd0, 8'h44, 4190210, 4190210, "half_odd");
        run_one(2'b01, 23'd4, 23'd2, 8'h55, 3, 1, "half_even");
        run_one(2'b10, 23'd123, 23'd456, 8'h66, 123, 456, "bypass10");
        run_one(2'b11, 23'd77, 23'd99, 8'h77, 77, 99, "bypass11");

        // Back-to-back stream, then a 4-cycle stall with junk on the inputs
        drive(1'b1, 2'b00, 23'd100, 23'd200, 8'hA1);
        step();
        drive(1'b1, 2'b01, 23'd8380000, 23'd417, 8'hA2);
        step();
        drive(1'b1, 2'b00, 23'd0, 23'd8380416, 8'hA3);
        step();
        held_sum   = sum;
        held_valid = out_valid;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 23'($urandom_range(8380416, 0)), 23'($urandom_range(8380416, 0)), 8'hEE);
            step();
            check("stall_sum_hold", 64'(sum), 64'(held_sum));
            check("stall_valid_hold", 64'(out_valid), 64'(held_valid));
        end
        en = 1'b1;
        drive(1'b0, 2'b00, 23'd0, 23'd0, 8'd0);
        for (int i = 0; i < 3; i++) step();
        check("stream_drained", 64'(pend.size()), 64'd0);

        // Reset between edges with two operations in flight
        drive(1'b1, 2'b00, 23'd11, 23'd22, 8'hB1);
        step();
        drive(1'b1, 2'b01, 23'd33, 23'd44, 8'hB2);
        step();
        drive(1'b0, 2'b00, 23'd0, 23'd0, 8'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_diff", 64'(diff), 64'd0);
        pend.delete();
        exp_valid = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Random run, modes 00/01, random enable and valid gaps
        issued = 0;
        while (issued < 10000) begin
            en = ($urandom_range(99, 0) < 85);
            drive($urandom_range(99, 0) < 90, 2'($urandom_range(1, 0)),
                  23'($urandom_range(8380416, 0)), 23'($urandom_range(8380416, 0)),
                  8'($urandom));
            if (en && in_valid) issued++;
            step();
        end
        en = 1'b1;
        drive(1'b0, 2'b00, 23'd0, 23'd0, 8'd0);
        for (int i = 0; i < 3; i++) step();
        check("random_drained", 64'(pend.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
